adder_err_eval_ctrl: RTL and testbench
======================================

// Module: adder_err_eval_ctrl
// PURPOSE
//  Sequencer for error evaluation of one WIDTH-bit approximate adder under test (DUT).
//  - Generates operand pairs. Drives them to the combinational DUT and samples its WIDTH+1-bit sum.
//  - Compares each DUT sum with an internal exact sum.
//  - Accumulates error count, maximum error distance and sum of absolute error over 2**SAMPLES_LOG2 samples.
//  - Sits between the host or testbench register interface and the adder instance.
// PARAMETERS
//  WIDTH        16            operand width; the DUT sum is WIDTH+1 bits wide
//  SAMPLES_LOG2 16            samples per run = 2**SAMPLES_LOG2 (legal range 1..2*WIDTH)
//  LFSR_SEED    32'hACE1_0001 reset and restart seed of the 2*WIDTH-bit operand LFSR; must be nonzero
// PORTS
//  clk          in   1                  rising-edge clock
//  rst_n        in   1                  synchronous, active-low reset
//  start        in   1                  single-cycle pulse; honoured only in IDLE or DONE
//  abort        in   1                  level; ends a run early
//  mode         in   1                  0 = LFSR random operands, 1 = counter sweep {a,b} = sample index
//  busy         out  1                  high in RUN and DRAIN
//  done         out  1                  high in DONE, until the next accepted start
//  dut_a        out  WIDTH              registered operand A to the DUT
//  dut_b        out  WIDTH              registered operand B to the DUT
//  dut_sum      in   WIDTH+1            DUT result, combinational from dut_a/dut_b
//  err_count    out  SAMPLES_LOG2+1     number of samples with dut_sum != exact sum
//  max_err      out  WIDTH+1            maximum |exact - dut_sum| seen in the run
//  sum_abs_err  out  WIDTH+1+SAMPLES_LOG2  sum of |exact - dut_sum|; sized so it cannot overflow
//  samples_done out  SAMPLES_LOG2+1     number of samples compared so far
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//  - State goes to IDLE. The LFSR loads LFSR_SEED.
//  - All outputs reset to 0: dut_a/dut_b, all statistics, busy, done.
//  Arithmetic:
//  - Exact sum = {1'b0,a} + {1'b0,b}, WIDTH+1 bits, unsigned.
//  - err = |exact - dut_sum|, WIDTH+1 bits, unsigned magnitude.
//  FSM states: IDLE, RUN, DRAIN, DONE.
//  - IDLE/DONE + start: clear all statistics and the sample index. Reload the LFSR seed.
//    Latch mode for the whole run. Go to RUN.
//  - RUN, issue: each cycle, drive the next operand pair on dut_a/dut_b and increment the index.
//  - RUN, compare: one cycle after issue, compare dut_sum against the exact sum of the operands
//    held in a pipeline register, then update the statistics.
//    Latency is 1 cycle from issue to compare.
//  - RUN -> DRAIN: after issuing 2**SAMPLES_LOG2 pairs. DRAIN lasts exactly 1 cycle and compares
//    the final pair. DRAIN -> DONE.
//  - Cycles from start to done are 2**SAMPLES_LOG2 + 2.
//  - abort in RUN: stop issuing and go to DRAIN, so the in-flight pair is still compared.
//    samples_done then reports the partial count. abort in any other state has no effect.
//  - start while busy is ignored. start and abort together in IDLE/DONE: start wins.
//  Statistics on compare:
//  - samples_done increments by 1.
//  - err_count increments by 1 if err != 0.
//  - max_err = max(max_err, err).
//  - sum_abs_err += err.
//  Operand generation:
//  - mode 1: {a,b} = zero-extended sample index; a is the upper half.
//  - mode 0: LFSR output; the LFSR advances once per issue.
//  Statistics hold their values in DONE until the next accepted start.
// CONFIGURATION
//  ERR_EVAL_WORST_CAPTURE_EN
//  - Defined: adds outputs worst_a and worst_b (WIDTH bits each, reset 0). They capture the
//    operands of the first sample that strictly raises max_err; ties keep the earlier pair.
//    Cleared on an accepted start.
//  - Undefined: these ports and registers are absent. All other behaviour is identical.
// STRUCTURE
//  - Package adder_eval_pkg holds: state enum eval_state_e (IDLE, RUN, DRAIN, DONE), a localparam
//    for the default LFSR tap mask for 2*WIDTH=32, and the function abs_diff().
//  - Sub-module eval_lfsr (Galois, 2*WIDTH bits): inputs load and step; output state.
//  - The FSM, the pipeline register and the accumulators live in the top-level module.
// TESTING
//  1. Exact adder as DUT, mode 1, SAMPLES_LOG2=8 -> done at cycle 258 after start;
//     err_count=0, max_err=0, sum_abs_err=0, samples_done=256.
//  2. DUT with sum[0] stuck at 0, mode 1, SAMPLES_LOG2=8 -> err_count=128, max_err=1,
//     sum_abs_err=128.
//  3. DUT = exact+4 when a[15], mode 0, SAMPLES_LOG2=10 -> max_err=4;
//     sum_abs_err = 4*err_count; samples_done=1024.
//  4. abort asserted for 1 cycle on the 11th RUN cycle -> DRAIN, then DONE;
//     samples_done=11 and busy low 2 cycles after abort.
//  5. start pulsed during RUN -> ignored, run length unchanged. rst_n low mid-RUN -> next cycle
//     IDLE with all outputs 0. A fresh start repeats the identical LFSR sequence.
//  6. With ERR_EVAL_WORST_CAPTURE_EN, injected errors 2, 5, 5 on samples 3, 7, 9 ->
//     worst_a/worst_b equal the sample-7 operands.

Source files
------------

// File: rtl/adder_eval_pkg.sv
// ----------------------------------------------------------------------------
// adder_eval_pkg
//   Shared types and helpers for the approximate-adder error evaluator.
//   - eval_state_e : sequencer states (IDLE, RUN, DRAIN, DONE)
//   - LFSR_TAPS_32 : Galois tap mask for the 32-bit operand LFSR
//                    (x^32 + x^22 + x^2 + x + 1, right-shifting form)
//   - abs_diff()   : unsigned magnitude of the difference of two values,
//                    evaluated at ABS_W bits; callers zero-extend their
//                    operands and truncate the result to their own width.
// ----------------------------------------------------------------------------
package adder_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } eval_state_e;

    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // Wide enough for a WIDTH+1 bit sum with WIDTH up to 64.
    localparam int ABS_W = 65;

    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] x,
                                                  input logic [ABS_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/adder_err_eval_ctrl_lfsr.sv
// ----------------------------------------------------------------------------
// eval_lfsr
//   Galois LFSR producing the packed random operand pair {a,b}.
//   Ports:
//     clk   in   rising-edge clock
//     rst_n in   synchronous active-low reset (loads SEED)
//     load  in   reload SEED (has priority over step)
//     step  in   advance one position
//     state out  N-bit current LFSR value
// ----------------------------------------------------------------------------
module eval_lfsr
    import adder_eval_pkg::*;
#(
    parameter int           N    = 32,
    parameter logic [N-1:0] TAPS = N'(LFSR_TAPS_32),
    parameter logic [N-1:0] SEED = N'(32'hACE1_0001)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    output logic [N-1:0] state
);

    always_ff @(posedge clk) begin
        if (!rst_n || load) begin
            state <= SEED;
        end else if (step) begin
            // Right-shifting Galois form: the bit shifted out toggles the taps.
            state <= {1'b0, state[N-1:1]} ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/adder_err_eval_ctrl.sv
// ----------------------------------------------------------------------------
// adder_err_eval_ctrl
//   Error-evaluation sequencer for one combinational WIDTH-bit approximate
//   adder. Issues 2**SAMPLES_LOG2 operand pairs (LFSR or index sweep),
//   compares each returned sum one cycle later with the exact sum and
//   accumulates error count, maximum error and sum of absolute errors.
//
//   Handshake: start is a one-cycle request accepted only in IDLE or DONE
//   (start beats abort there); abort is a level honoured only in RUN. busy is
//   high in RUN/DRAIN, done is high in DONE until the next accepted start.
//
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     start, abort      run control
//     mode              0 = LFSR operands, 1 = {a,b} = sample index (latched)
//     busy, done        status
//     dut_a, dut_b      registered operands to the adder under test
//     dut_sum           WIDTH+1 bit result from the adder under test
//     err_count         samples with a wrong sum
//     max_err           largest |exact - dut_sum|
//     sum_abs_err       sum of |exact - dut_sum|
//     samples_done      samples compared so far
//     worst_a, worst_b  (ERR_EVAL_WORST_CAPTURE_EN only) operands of the
//                       first sample that strictly raised max_err
//
//   Optional feature macro: ERR_EVAL_WORST_CAPTURE_EN
// ----------------------------------------------------------------------------
module adder_err_eval_ctrl
    import adder_eval_pkg::*;
#(
    parameter int          WIDTH        = 16,
    parameter int          SAMPLES_LOG2 = 16,
    parameter logic [31:0] LFSR_SEED    = 32'hACE1_0001
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          mode,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              dut_a,
    output logic [WIDTH-1:0]              dut_b,
    input  logic [WIDTH:0]                dut_sum,
    output logic [SAMPLES_LOG2:0]         err_count,
    output logic [WIDTH:0]                max_err,
    output logic [WIDTH+SAMPLES_LOG2:0]   sum_abs_err,
    output logic [SAMPLES_LOG2:0]         samples_done
`ifdef ERR_EVAL_WORST_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]              worst_a,
    output logic [WIDTH-1:0]              worst_b
`endif
);

    localparam int OPW = 2 * WIDTH;
    localparam int SAW = WIDTH + 1 + SAMPLES_LOG2;

    eval_state_e state, next_state;

    logic                    accept_start;
    logic                    issue;
    logic                    last_issue;
    logic [SAMPLES_LOG2-1:0] idx;
    logic                    run_mode;
    logic                    pipe_valid;
    logic [OPW-1:0]          lfsr_state;
    logic [OPW-1:0]          sweep_ops;
    logic [OPW-1:0]          next_ops;
    logic [WIDTH:0]          exact_sum;
    logic [WIDTH:0]          err;

    // ------------------------------------------------------------------
    // Operand sources
    // ------------------------------------------------------------------
    eval_lfsr #(
        .N    (OPW),
        .TAPS (OPW'(LFSR_TAPS_32)),
        .SEED (OPW'(LFSR_SEED))
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_start),
        .step  (issue && !run_mode),
        .state (lfsr_state)
    );

    always_comb begin
        sweep_ops                    = '0;
        sweep_ops[SAMPLES_LOG2-1:0]  = idx;
    end

    assign next_ops   = run_mode ? sweep_ops : lfsr_state;
    assign last_issue = (idx == '1);

    // dut_a/dut_b double as the pipeline register: they hold the pair whose
    // sum is on dut_sum during the compare cycle.
    assign exact_sum = {1'b0, dut_a} + {1'b0, dut_b};
    assign err       = (WIDTH+1)'(abs_diff(ABS_W'(exact_sum), ABS_W'(dut_sum)));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        issue        = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    next_state   = RUN;
                end
            end
            RUN: begin
                // The abort cycle still issues; DRAIN then compares that pair.
                issue = 1'b1;
                if (abort || last_issue) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                next_state = DONE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Issue pipeline and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dut_a        <= '0;
            dut_b        <= '0;
            idx          <= '0;
            run_mode     <= 1'b0;
            pipe_valid   <= 1'b0;
            err_count    <= '0;
            max_err      <= '0;
            sum_abs_err  <= '0;
            samples_done <= '0;
`ifdef ERR_EVAL_WORST_CAPTURE_EN
            worst_a      <= '0;
            worst_b      <= '0;
`endif
        end else if (accept_start) begin
            idx          <= '0;
            run_mode     <= mode;
            pipe_valid   <= 1'b0;
            err_count    <= '0;
            max_err      <= '0;
            sum_abs_err  <= '0;
            samples_done <= '0;
`ifdef ERR_EVAL_WORST_CAPTURE_EN
            worst_a      <= '0;
            worst_b      <= '0;
`endif
        end else begin
            pipe_valid <= issue;
            if (issue) begin
                dut_a <= next_ops[OPW-1:WIDTH];
                dut_b <= next_ops[WIDTH-1:0];
                idx   <= idx + 1'b1;
            end
            if (pipe_valid) begin
                samples_done <= samples_done + 1'b1;
                sum_abs_err  <= sum_abs_err + SAW'(err);
                if (err != '0) begin
                    err_count <= err_count + 1'b1;
                end
                // Strict compare: ties keep the earlier maximum.
                if (err > max_err) begin
                    max_err <= err;
`ifdef ERR_EVAL_WORST_CAPTURE_EN
                    worst_a <= dut_a;
                    worst_b <= dut_b;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_err_eval_ctrl.sv
// ----------------------------------------------------------------------------
// tb_adder_err_eval_ctrl
//   Self-checking bench for adder_err_eval_ctrl (WIDTH=16, SAMPLES_LOG2=8).
//   The adder under test is a behavioural function with selectable faults.
//   Expected operand streams and run statistics come from a reference model
//   that walks the sample list with plain arithmetic.
// ----------------------------------------------------------------------------
module tb_adder_err_eval_ctrl;

    localparam int          W    = 16;
    localparam int          SL   = 8;
    localparam int          N    = 1 << SL;
    localparam logic [31:0] SEED = 32'hACE1_0001;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic              start, abort, mode;
    logic              busy, done;
    logic [W-1:0]      dut_a, dut_b;
    logic [W:0]        dut_sum;
    logic [SL:0]       err_count;
    logic [W:0]        max_err;
    logic [W+SL:0]     sum_abs_err;
    logic [SL:0]       samples_done;
`ifdef ERR_EVAL_WORST_CAPTURE_EN
    logic [W-1:0]      worst_a, worst_b;
`endif

    int fault;

    adder_err_eval_ctrl #(
        .WIDTH        (W),
        .SAMPLES_LOG2 (SL),
        .LFSR_SEED    (SEED)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .mode         (mode),
        .busy         (busy),
        .done         (done),
        .dut_a        (dut_a),
        .dut_b        (dut_b),
        .dut_sum      (dut_sum),
        .err_count    (err_count),
        .max_err      (max_err),
        .sum_abs_err  (sum_abs_err),
        .samples_done (samples_done)
`ifdef ERR_EVAL_WORST_CAPTURE_EN
        ,
        .worst_a      (worst_a),
        .worst_b      (worst_b)
`endif
    );

    // ---------------- adder under test ----------------
    // 0 exact, 1 sum[0] stuck 0, 2 +4 when a[15], 3 injected errors at
    // sweep samples 3/7/9, 4 data-dependent subtractive error.
    function automatic logic [W:0] adder_model(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input int f);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        case (f)
            1: s[0] = 1'b0;
            2: if (a[W-1]) s = s + (W+1)'(4);
            3: if (a == '0) begin
                   if (b == W'(3))      s = s + (W+1)'(2);
                   else if (b == W'(7)) s = s + (W+1)'(5);
                   else if (b == W'(9)) s = s - (W+1)'(5);
               end
            4: if (a[1] && b[2]) s = s - (W+1)'(a[4:2]);
            default: ;
        endcase
        return s;
    endfunction

    assign dut_sum = adder_model(dut_a, dut_b, fault);

    // ---------------- scoreboard ----------------
    logic [2*W-1:0] exp_q[$];
    longint         exp_cnt, exp_max, exp_sum;
    logic [2*W-1:0] exp_worst;
    int             n_checks = 0;
    int             n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? adder_eval_pkg::LFSR_TAPS_32 : 32'h0);
    endfunction

    // Reference: list the n issued pairs, then fold the error statistics.
    task automatic build_model(input logic m, input int f, input int n);
        logic [31:0]    s;
        logic [2*W-1:0] ops;
        longint         exact, got, e;
        exp_q.delete();
        exp_cnt   = 0;
        exp_max   = 0;
        exp_sum   = 0;
        exp_worst = '0;
        s = SEED;
        for (int i = 0; i < n; i++) begin
            ops = m ? (2*W)'(i) : s;
            s   = lfsr_next(s);
            exp_q.push_back(ops);
            exact = longint'(ops[2*W-1:W]) + longint'(ops[W-1:0]);
            got   = longint'(adder_model(ops[2*W-1:W], ops[W-1:0], f));
            e     = (exact >= got) ? exact - got : got - exact;
            if (e != 0) exp_cnt++;
            if (e > exp_max) begin
                exp_max   = e;
                exp_worst = ops;
            end
            exp_sum += e;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string name);
        check_val({name, ":busy"},    busy, 0);
        check_val({name, ":done"},    done, 0);
        check_val({name, ":ops"},     {dut_a, dut_b}, 0);
        check_val({name, ":errcnt"},  err_count, 0);
        check_val({name, ":maxerr"},  max_err, 0);
        check_val({name, ":sumerr"},  sum_abs_err, 0);
        check_val({name, ":samples"}, samples_done, 0);
`ifdef ERR_EVAL_WORST_CAPTURE_EN
        check_val({name, ":worst"},   {worst_a, worst_b}, 0);
`endif
    endtask

    task automatic run_and_check(input string name, input logic m, input int f,
                                 input int abort_at, input int glitch_at);
        int n_issue, cyc, waited;
        logic [2*W-1:0] ops;
        n_issue = (abort_at > 0) ? abort_at : N;
        fault   = f;
        build_model(m, f, n_issue);

        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(posedge clk);
        cyc = 1;
        #1 start = 1'b0;
        mode = ~m;   // must have been latched at start
        @(negedge clk);
        check_val({name, ":busy_run"}, busy, 1);
        check_val({name, ":done_run"}, done, 0);

        for (int k = 1; k <= n_issue; k++) begin
            if (k == abort_at)  abort = 1'b1;
            if (k == glitch_at) start = 1'b1;
            @(posedge clk);
            cyc++;
            #1 abort = 1'b0;
            start = 1'b0;
            @(negedge clk);
            ops = exp_q.pop_front();
            check_val({name, ":ops"}, {dut_a, dut_b}, ops);
        end

        waited = 0;
        while (!done && waited < 8) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            waited++;
        end
        check_val({name, ":done"},    done, 1);
        check_val({name, ":cycles"},  cyc, n_issue + 2);
        check_val({name, ":busy"},    busy, 0);
        check_val({name, ":errcnt"},  err_count, exp_cnt);
        check_val({name, ":maxerr"},  max_err, exp_max);
        check_val({name, ":sumerr"},  sum_abs_err, exp_sum);
        check_val({name, ":samples"}, samples_done, n_issue);
`ifdef ERR_EVAL_WORST_CAPTURE_EN
        check_val({name, ":worst"},   {worst_a, worst_b}, exp_worst);
`endif
        // Statistics and done must hold while idle in DONE.
        repeat (3) @(negedge clk);
        check_val({name, ":hold_done"},    done, 1);
        check_val({name, ":hold_samples"}, samples_done, n_issue);
        check_val({name, ":hold_sumerr"},  sum_abs_err, exp_sum);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "timeout");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        mode  = 1'b0;
        fault = 0;
        do_reset();
        @(negedge clk);
        check_all_zero("reset");

        // abort outside RUN is ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("idle_abort:busy", busy, 0);

        run_and_check("exact_sweep", 1'b1, 0, 0, 0);
        check_val("exact_sweep:errcnt_const", err_count, 0);
        run_and_check("lsb_stuck",   1'b1, 1, 0, 0);
        check_val("lsb_stuck:errcnt_const", err_count, N / 2);
        check_val("lsb_stuck:maxerr_const", max_err, 1);
        run_and_check("a15_plus4",   1'b0, 2, 0, 0);
        check_val("a15_plus4:maxerr_const", max_err, 4);
        check_val("a15_plus4:sum_ratio", sum_abs_err, 4 * err_count);
        run_and_check("abort11",     1'b0, 4, 11, 0);
        run_and_check("start_glitch", 1'b1, 4, 0, 50);

        // reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        run_and_check("after_reset", 1'b0, 4, 0, 0);

        run_and_check("inject", 1'b1, 3, 0, 0);
        check_val("inject:maxerr_const", max_err, 5);
        check_val("inject:errcnt_const", err_count, 3);
`ifdef ERR_EVAL_WORST_CAPTURE_EN
        check_val("inject:worst_const", {worst_a, worst_b}, 7);
`endif

        for (int r = 0; r < 6; r++) begin
            logic m;
            int   f, ab, gl;
            m  = 1'($urandom_range(0, 1));
            f  = $urandom_range(0, 4);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, N) : 0;
            gl = $urandom_range(2, N);
            run_and_check($sformatf("rand%0d", r), m, f, ab, gl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
